// File: rtl/edge_propagator_pkg.sv
// Shared types and constants for the edge propagator pair.
//   ep_state_e               : transmitter handshake FSM states
//   EP_SYNC_STAGES_DEFAULT   : default depth of the ack synchronizer
//   EP_SYNC_STAGES_MIN       : smallest legal synchronizer depth
package edge_propagator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2
   } ep_state_e;

   localparam int unsigned EP_SYNC_STAGES_DEFAULT = 2;
   localparam int unsigned EP_SYNC_STAGES_MIN     = 2;

endpackage

// File: rtl/edge_propagator_ack_sync.sv
// N-flop level synchronizer for the ack returned by the receiver.
//   clk_i  : destination (transmitter) clock
//   rstn_i : asynchronous active-low reset, all stages clear to 0
//   d_i    : asynchronous level input
//   q_o    : synchronized level, STAGES cycles behind d_i
// CDC crossing: the sync_q chain is the clock-domain boundary and must be
// covered by the async_reg / false-path constraints on the first stage.
module edge_propagator_ack_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   (* async_reg = "true" *) logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/edge_propagator_tx_cnt.sv
// Source-domain transmitter of the edge propagator pair. Turns event pulses
// into a four-phase valid/ack handshake and queues events that arrive while
// a handshake is in flight.
//   clk_i      : source clock
//   rstn_i     : asynchronous active-low reset
//   valid_i    : event pulse, one event per high cycle
//   ack_i      : ack level from the receiver (asynchronous)
//   clr_i      : synchronous clear of overflow_o
//   valid_o    : registered request level to the receiver
//   busy_o     : handshake in flight or events pending
//   pending_o  : number of queued events
//   overflow_o : sticky, an event was dropped on a full counter
module edge_propagator_tx_cnt
   import edge_propagator_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = EP_SYNC_STAGES_DEFAULT,
   parameter int unsigned CNT_WIDTH   = 4
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 valid_i,
   input  logic                 ack_i,
   input  logic                 clr_i,
   output logic                 valid_o,
   output logic                 busy_o,
   output logic [CNT_WIDTH-1:0] pending_o,
   output logic                 overflow_o
);

   if (SYNC_STAGES < EP_SYNC_STAGES_MIN || CNT_WIDTH < 1) begin : g_param_check
      $error("edge_propagator_tx_cnt: SYNC_STAGES must be >= 2 and CNT_WIDTH >= 1");
   end

   localparam int unsigned          HOLD_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [HOLD_W-1:0]    HOLD_INIT = HOLD_W'(SYNC_STAGES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic                 ack_s;
   ep_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0] pending_q, pending_d;
   logic [HOLD_W-1:0]    holdoff_q, holdoff_d;
   logic                 overflow_q, overflow_d;
   logic                 valid_q, valid_d;
   logic                 launch;
   logic                 drop;

   edge_propagator_ack_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (ack_i),
      .q_o    (ack_s)
   );

   // A launch only ever happens with ack_s low, so every request the
   // receiver sees is a fresh rising edge.
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q != '0 && !ack_s && holdoff_q == '0) begin
               launch  = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack_s) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!ack_s) begin
               if (pending_q != '0) begin
                  launch  = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      valid_d = (state_d == ST_REQ);
   end

   always_comb begin
      pending_d = pending_q;
      drop      = 1'b0;
      if (valid_i && !launch) begin
         if (pending_q == CNT_MAX) begin
            drop = 1'b1;
         end else begin
            pending_d = pending_q + 1'b1;
         end
      end else if (!valid_i && launch) begin
         pending_d = pending_q - 1'b1;
      end
      // A new drop outranks a clear in the same cycle.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_i) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      holdoff_d = (holdoff_q != '0) ? holdoff_q - 1'b1 : holdoff_q;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         holdoff_q  <= HOLD_INIT;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         holdoff_q  <= holdoff_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
      end
   end

   assign valid_o    = valid_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;
   assign busy_o     = (state_q != ST_IDLE) || (pending_q != '0);

endmodule
